accum_delta_fifo: RTL and testbench

ACCUM_DELTA_FIFO -- requirements
Module: accum_delta_fifo

---
 rtl/accum_delta_fifo_if.sv | 24 ++
 rtl/accum_delta_fifo.sv | 100 ++++++++++
 tb/tb_accum_delta_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/accum_delta_fifo_if.sv
// Bundles the sample input, the FIFO output handshake and the status outputs of accum_delta_fifo.
// master is the design side; slave is the upstream/downstream side.
interface accum_delta_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  logic [WIDTH-1:0]         x;
  logic                     en;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fill;
  logic [15:0]              drop_count;

  modport master (
    input  x, en, out_ready,
    output out_data, out_valid, fill, drop_count
  );

  modport slave (
    output x, en, out_ready,
    input  out_data, out_valid, fill, drop_count
  );
endinterface

// File: rtl/accum_delta_fifo.sv
// Differentiates a stream of accumulator samples and queues the deltas in a small FIFO.
// Define ACCUM_DELTA_DROPCNT_EN to count deltas lost to overflow; otherwise drop_count reads 0.
module accum_delta_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  accum_delta_fifo_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = DEPTH[AW:0];
  localparam logic [AW:0] FillOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      fill_q;

  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic [WIDTH-1:0] delta;

  always_comb begin
    delta  = bus.x - prev_q;
    push   = (state_q == StRun) && bus.en;
    pop    = (fill_q != '0) && bus.out_ready;
    full   = (fill_q == FullLevel);
    // A full FIFO still accepts when the head leaves on the same edge.
    accept = push && (!full || pop);
  end

  // prev only tracks x while en is high; dropping en forces a re-prime.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prev_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            prev_q  <= bus.x;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.en) prev_q <= bus.x;
          else        state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= delta;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrOne;
      if (accept && !pop)      fill_q <= fill_q + FillOne;
      else if (!accept && pop) fill_q <= fill_q - FillOne;
    end
  end

  assign bus.fill      = fill_q;
  assign bus.out_valid = (fill_q != '0);
  // Storage is not reset, so mask the head while empty.
  assign bus.out_data  = (fill_q != '0) ? mem[rd_ptr_q] : '0;

`ifdef ACCUM_DELTA_DROPCNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (push && full && !pop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_accum_delta_fifo.sv
// Scoreboard bench for accum_delta_fifo: a queue-based reference model predicts every delta,
// and a negedge monitor compares the FIFO head, occupancy and drop count against it.
module tb_accum_delta_fifo;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

`ifdef ACCUM_DELTA_DROPCNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  accum_delta_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  accum_delta_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;

  // Reference model: whether a previous sample exists, its value, and the expected FIFO queue.
  logic [WIDTH-1:0] exp_q[$];
  bit               primed;
  logic [WIDTH-1:0] m_prev;
  int               m_fill;
  int               m_drop;
  int               exp_fill;
  int               exp_drop;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    primed   = 1'b0;
    m_prev   = '0;
    m_fill   = 0;
    m_drop   = 0;
    exp_fill = 0;
    exp_drop = 0;
  endtask

  // Drive one cycle of inputs just after a posedge and predict the effect of the following edge.
  task automatic step(input bit e, input logic [WIDTH-1:0] xv, input bit r);
    bit pop;
    @(posedge clk);
    #1;
    exp_fill      = m_fill;
    exp_drop      = m_drop;
    bus.en        = e;
    bus.x         = xv;
    bus.out_ready = r;
    pop = (m_fill > 0) && r;
    if (e && primed) begin
      if ((m_fill < int'(DEPTH)) || pop) begin
        exp_q.push_back(xv - m_prev);
        m_fill++;
      end else if (DropEn && (m_drop < 65535)) begin
        m_drop++;
      end
    end
    if (pop) m_fill--;
    primed = e;
    if (e) m_prev = xv;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("fill", 64'(bus.fill), 64'(exp_fill));
      check("out_valid", 64'(bus.out_valid), 64'(exp_fill != 0));
      check("drop_count", 64'(bus.drop_count), 64'(exp_drop));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_data: got 0x%0h, want no entry at %0t", bus.out_data, $time);
        end else begin
          check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end else begin
        check("out_data_empty", 64'(bus.out_data), 64'd0);
      end
    end
  end

  initial begin
    int unsigned base_out;
    logic [WIDTH-1:0] acc;

    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fill", 64'(bus.fill), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_data", 64'(bus.out_data), 64'd0);
    check("reset_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Counting ramp: every delta is 1.
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(i), 1'b1);
    step(1'b0, '0, 1'b1);

    // Wrap-around subtraction.
    step(1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 32'h0000_0002, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Overflow with the consumer stalled, then push and pop together while full.
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(i * 10), 1'b0);
    step(1'b1, WIDTH'(70), 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("full_fill", 64'(bus.fill), 64'd4);
    check("full_drops", 64'(bus.drop_count), DropEn ? 64'd2 : 64'd0);
    check("full_head", 64'(bus.out_data), 64'd10);
    repeat (5) step(1'b0, '0, 1'b1);

    // A gap in en re-primes: only two deltas, both 3.
    base_out = n_out;
    step(1'b1, WIDTH'(5), 1'b1);
    step(1'b1, WIDTH'(8), 1'b1);
    step(1'b0, WIDTH'(100), 1'b1);
    step(1'b1, WIDTH'(200), 1'b1);
    step(1'b1, WIDTH'(203), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    check("gap_delta_count", 64'(n_out - base_out), 64'd2);

    // Asynchronous reset with three entries queued.
    step(1'b1, WIDTH'(1000), 1'b0);
    step(1'b1, WIDTH'(1010), 1'b0);
    step(1'b1, WIDTH'(1030), 1'b0);
    step(1'b1, WIDTH'(1060), 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("pre_reset_fill", 64'(bus.fill), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("async_reset_fill", 64'(bus.fill), 64'd0);
    check("async_reset_valid", 64'(bus.out_valid), 64'd0);
    check("async_reset_data", 64'(bus.out_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    base_out = n_out;
    step(1'b1, WIDTH'(7), 1'b1);
    step(1'b1, WIDTH'(9), 1'b1);
    @(negedge clk);
    #1;
    check("reprime_no_output", 64'(bus.out_valid), 64'd0);
    repeat (3) step(1'b0, '0, 1'b1);
    check("reprime_delta_count", 64'(n_out - base_out), 64'd1);

    // Randomized traffic with a running accumulator and occasional jumps.
    acc = WIDTH'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) acc = WIDTH'($urandom);
      else acc = acc + WIDTH'($urandom_range(0, 50));
      step($urandom_range(0, 3) != 0, acc, $urandom_range(0, 1) == 1);
    end
    repeat (6) step(1'b0, '0, 1'b1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
